tpu_c_readout: RTL and testbench

- Downstream stage of the 4x4 systolic matrix unit; starts after the unit drops busy.
- Reads the int32 result buffer (C), one 128-bit entry per cycle.
- Requantizes each lane to int8 (scale, rounding shift, saturate) and streams packed 32-bit words to the host over a valid/ready interface.
- Lanes outside N are masked.

---
 rtl/tpu_c_readout_pkg.sv | 23 ++
 rtl/tpu_c_readout_requant_lane.sv | 53 +++++
 rtl/tpu_c_readout.sv | 173 +++++++++++++++++
 tb/tb_tpu_c_readout.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_c_readout_pkg.sv
// Shared definitions for the C-buffer readout stage: FSM encoding, lane
// count, int8 saturation limits, requant product width and the layout of one
// output FIFO entry.
package tpu_readout_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int LANES    = 4;
    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;
    // signed 32-bit acc times zero-extended 16-bit scale
    localparam int PROD_W   = 49;

    typedef struct packed {
        logic [8*LANES-1:0] data;
        logic [LANES-1:0]   mask;
        logic               last;
    } out_word_t;
endpackage

// File: rtl/tpu_c_readout_requant_lane.sv
// One requant lane: acc * scale + rounding bias, registered (stage 1), then an
// arithmetic right shift and int8 saturation (stage 2, combinational, feeding
// the FIFO write). Invalid lanes produce 0.
// Ports: clk, rst_n; acc (signed), scale (unsigned), shift (0..31), lane_valid;
//        q (int8 result), q_valid (registered lane_valid).
module tpu_requant_lane
    import tpu_readout_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] acc,
    input  logic [15:0]      scale,
    input  logic [4:0]       shift,
    input  logic             lane_valid,
    output logic [7:0]       q,
    output logic             q_valid
);
    localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(INT8_MAX);
    localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(INT8_MIN);

    logic signed [PROD_W-1:0] w_prod, w_bias, w_sum, w_shr, r_sum;
    logic                     r_lv;

    always_comb begin
        w_prod = PROD_W'($signed(acc)) * PROD_W'($signed({1'b0, scale}));
        // round-half-up bias; a zero shift needs none
        w_bias = (shift == 5'd0) ? '0 : (PROD_W'(1) << (shift - 5'd1));
        w_sum  = w_prod + w_bias;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_lv  <= 1'b0;
        end else begin
            r_sum <= w_sum;
            r_lv  <= lane_valid;
        end
    end

    always_comb begin
        w_shr = r_sum >>> shift;
        q     = '0;
        if (r_lv) begin
            if (w_shr > SAT_HI)      q = SAT_HI[7:0];
            else if (w_shr < SAT_LO) q = SAT_LO[7:0];
            else                     q = w_shr[7:0];
        end
        q_valid = r_lv;
    end
endmodule

// File: rtl/tpu_c_readout.sv
// Readout of the systolic unit's int32 C buffer. Reads entries linearly
// (column-block major), requantizes 4 lanes to int8 and streams packed words
// through a show-ahead FIFO over valid/ready. Read issue is credit-limited by
// FIFO occupancy plus reads still in the pipeline, so the FIFO cannot overflow.
// Ports: clk, rst_n; start/M/N/scale/shift job request; busy, done status;
//        C_wr_en, C_index, C_data_out C-buffer read port (1-cycle latency);
//        out_valid/out_ready/out_data/out_mask/out_last output stream.
module tpu_c_readout
    import tpu_readout_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ACC_W      = 32,
    parameter int IDX_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             M,
    input  logic [7:0]             N,
    input  logic [15:0]            scale,
    input  logic [4:0]             shift,
    output logic                   busy,
    output logic                   done,
    output logic                   C_wr_en,
    output logic [IDX_W-1:0]       C_index,
    input  logic [LANES*ACC_W-1:0] C_data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*LANES-1:0]     out_data,
    output logic [LANES-1:0]       out_mask,
    output logic                   out_last
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    state_t           r_state;
    logic [7:0]       r_m, r_n, r_row, r_cb;
    logic [15:0]      r_scale;
    logic [4:0]       r_shift;
    logic [IDX_W-1:0] r_total, r_addr;
    logic             r_busy, r_done;
    logic [CNT_W-1:0] r_count, r_inflight;
    logic [PTR_W-1:0] r_wptr, r_rptr;
    out_word_t        r_mem [FIFO_DEPTH];
    // [0]: read data on C_data_out, [1]: lane stage-1 registers hold it
    logic [1:0]       r_vld_pipe, r_last_pipe;
    logic [LANES-1:0] r_mask_d;

    logic             w_issue, w_is_last, w_push, w_pop;
    logic [CNT_W-1:0] w_cnt_nxt, w_infl_nxt;
    logic [LANES-1:0] w_mask, w_lane_v, w_lmask;
    logic [8*LANES-1:0] w_data;
    logic [8:0]       w_nblk;
    logic [IDX_W-1:0] w_total;
    out_word_t        w_word;

    always_comb begin
        w_nblk    = ({1'b0, N} + 9'd3) >> 2;
        w_total   = IDX_W'(M) * IDX_W'(w_nblk);
        w_issue   = (r_state == S_RUN) &&
                    (({1'b0, r_count} + {1'b0, r_inflight}) < (CNT_W+1)'(FIFO_DEPTH));
        w_is_last = (r_addr == r_total - IDX_W'(1));
        w_push    = r_vld_pipe[1];
        w_pop     = out_valid & out_ready;
        w_cnt_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_infl_nxt = r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
        for (int l = 0; l < LANES; l++)
            w_mask[l] = ({r_cb, 2'b00} + 10'(l)) < {2'b00, r_n};
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] w_q;
        tpu_requant_lane #(.ACC_W(ACC_W)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .acc        (C_data_out[(LANES-1-g)*ACC_W +: ACC_W]),
            .scale      (r_scale),
            .shift      (r_shift),
            .lane_valid (r_mask_d[g]),
            .q          (w_q),
            .q_valid    (w_lane_v[g])
        );
        assign w_data[(LANES-1-g)*8 +: 8] = w_q;
        assign w_lmask[LANES-1-g]         = w_lane_v[g];
    end

    assign w_word = '{data: w_data, mask: w_lmask, last: r_last_pipe[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_m <= '0; r_n <= '0; r_scale <= '0; r_shift <= '0;
            r_total <= '0; r_addr <= '0; r_row <= '0; r_cb <= '0;
            r_busy <= 1'b0; r_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m <= M; r_n <= N; r_scale <= scale; r_shift <= shift;
                        r_total <= w_total;
                        r_addr <= '0; r_row <= '0; r_cb <= '0;
                        if (M == 8'd0 || N == 8'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_addr <= r_addr + IDX_W'(1);
                        if (r_row == r_m - 8'd1) begin
                            r_row <= '0;
                            r_cb  <= r_cb + 8'd1;
                        end else begin
                            r_row <= r_row + 8'd1;
                        end
                        if (w_is_last) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // look ahead so done follows the final handshake directly
                    if (w_cnt_nxt == '0 && w_infl_nxt == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0; r_inflight <= '0;
            r_wptr <= '0; r_rptr <= '0;
            r_vld_pipe <= '0; r_last_pipe <= '0; r_mask_d <= '0;
        end else begin
            r_count     <= w_cnt_nxt;
            r_inflight  <= w_infl_nxt;
            r_vld_pipe  <= {r_vld_pipe[0], w_issue};
            r_last_pipe <= {r_last_pipe[0], w_issue & w_is_last};
            r_mask_d    <= w_issue ? w_mask : '0;
            if (w_push)
                r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_rptr + PTR_W'(1);
        end
    end

    // storage only; occupancy lives in r_count, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_word;
    end

    always_comb begin
        busy      = r_busy;
        done      = r_done;
        C_wr_en   = 1'b0;
        C_index   = w_issue ? r_addr : '0;
        out_valid = (r_count != '0);
        out_data  = out_valid ? r_mem[r_rptr].data : '0;
        out_mask  = out_valid ? r_mem[r_rptr].mask : '0;
        out_last  = out_valid ? r_mem[r_rptr].last : 1'b0;
    end
endmodule

// File: tb/tb_tpu_c_readout.sv
// Bench for tpu_c_readout: registered C-buffer model, directed scenarios and
// random jobs checked against an arithmetic requant/masking reference.
module tb_tpu_c_readout;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
        logic        l;
    } exp_t;

    logic         clk, rst_n, start;
    logic [7:0]   M, N;
    logic [15:0]  scale;
    logic [4:0]   shift;
    logic         busy, done, C_wr_en;
    logic [15:0]  C_index;
    logic [127:0] C_data_out;
    logic         out_valid, out_ready, out_last;
    logic [31:0]  out_data;
    logic [3:0]   out_mask;

    logic [127:0] cmem [0:255];
    int n_cmp = 0, n_err = 0;
    int first_valid_k, done_k, last_hs_k;
    logic [31:0] obs_q[$];
    logic [3:0]  obs_m[$];

    tpu_c_readout dut (
        .clk(clk), .rst_n(rst_n), .start(start), .M(M), .N(N),
        .scale(scale), .shift(shift), .busy(busy), .done(done),
        .C_wr_en(C_wr_en), .C_index(C_index), .C_data_out(C_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // C buffer: data valid the cycle after the address
    always @(posedge clk) C_data_out <= cmem[C_index[7:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pk(int a, int b, int c, int d);
        return {a[31:0], b[31:0], c[31:0], d[31:0]};
    endfunction

    function automatic logic [7:0] req(logic [31:0] acc, logic [15:0] sc, logic [4:0] sh);
        longint p;
        p = longint'($signed(acc)) * longint'(sc);
        if (sh != 0) p = p + (longint'(1) << (sh - 1));
        p = p >>> sh;
        if (p > 127) p = 127;
        else if (p < -128) p = -128;
        return p[7:0];
    endfunction

    function automatic logic [31:0] rnd_acc();
        logic [31:0] v;
        v = $urandom >> $urandom_range(0, 31);
        return $urandom_range(0, 1) ? -v : v;
    endfunction

    task automatic run_job(input string tag, input int m, input int n, input logic [15:0] sc,
                           input logic [4:0] sh, input int rmode, input bit inject);
        exp_t eq[$];
        exp_t e;
        int t, nxt, popped;
        bit prev_stall, done_seen;
        logic [36:0] prev;
        t = m * ((n + 3) / 4);
        for (int i = 0; i < t; i++) begin
            int cb, row;
            cb = i / m; row = i % m;
            e = '0;
            for (int l = 0; l < 4; l++) begin
                if (cb * 4 + l < n) begin
                    e.d[31 - 8*l -: 8] = req(cmem[i][127 - 32*l -: 32], sc, sh);
                    e.m[3 - l] = 1'b1;
                end
            end
            e.l = (i == t - 1);
            eq.push_back(e);
        end
        obs_q.delete(); obs_m.delete();
        first_valid_k = -1; done_k = -1; last_hs_k = -1;
        M = m[7:0]; N = n[7:0]; scale = sc; shift = sh; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nxt = 1; popped = 0; prev_stall = 0; done_seen = 0; prev = '0;
        for (int k = 0; k < 4000 && !done_seen; k++) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (inject) begin
                start = (k == 2);
                if (k == 2) begin M = 8'd9; N = 8'd9; scale = 16'd7; shift = 5'd3; end
            end
            if (k == 0) chk({tag, "_busy0"}, busy, (t > 0));
            chk({tag, "_wr_en"}, C_wr_en, 0);
            if (C_index != 0) begin
                chk({tag, "_cidx"}, C_index, nxt);
                nxt++;
            end
            if (t > 0) chk({tag, "_credit"}, (nxt - popped) <= 4, 1);
            if (prev_stall) begin
                chk({tag, "_hold_v"}, out_valid, 1);
                chk({tag, "_hold_d"}, {out_data, out_mask, out_last}, prev);
            end
            if (out_valid && first_valid_k < 0) first_valid_k = k;
            if (out_valid && out_ready) begin
                if (eq.size() == 0) begin
                    chk({tag, "_extra_word"}, out_data, 0);
                end else begin
                    e = eq.pop_front();
                    chk({tag, "_data"}, out_data, e.d);
                    chk({tag, "_mask"}, out_mask, e.m);
                    chk({tag, "_last"}, out_last, e.l);
                end
                obs_q.push_back(out_data);
                obs_m.push_back(out_mask);
                popped++;
                last_hs_k = k;
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_data, out_mask, out_last};
            if (done) begin
                done_seen = 1; done_k = k;
                chk({tag, "_busy_at_done"}, busy, 0);
                chk({tag, "_words_left"}, eq.size(), 0);
                if (t > 0) chk({tag, "_done_lat"}, done_k, last_hs_k + 1);
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_timeout"}, done_seen, 1);
        if (t > 0) chk({tag, "_addr_count"}, nxt, t);
        if (!done_seen) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_mask"}, out_mask, 0);
        chk({tag, "_cidx"}, C_index, 0);
        chk({tag, "_wr_en"}, C_wr_en, 0);
    endtask

    task automatic scenario1(input string tag);
        cmem[0] = pk(100, -100, 300, -300);
        run_job(tag, 1, 4, 16'd1, 5'd0, 0, 0);
        chk({tag, "_first_valid"}, first_valid_k, 3);
        chk({tag, "_nwords"}, obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk({tag, "_word"}, obs_q[0], 32'h649C7F80);
            chk({tag, "_wmask"}, obs_m[0], 4'hF);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; M = '0; N = '0; scale = '0; shift = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) cmem[i] = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        scenario1("s1");

        cmem[0] = pk(5, -5, 7, 0);
        run_job("rnd1", 1, 4, 16'd1, 5'd1, 0, 0);
        if (obs_q.size() > 0) chk("rnd1_word", obs_q[0], 32'h03FE0400);
        cmem[0] = pk(7, -7, 0, 1000);
        run_job("rnd2", 1, 4, 16'd3, 5'd2, 0, 0);
        if (obs_q.size() > 0) chk("rnd2_word", obs_q[0], 32'h05FB007F);

        for (int i = 0; i < 4; i++) cmem[i] = pk(rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc());
        run_job("mask", 2, 6, 16'd2, 5'd4, 0, 0);
        chk("mask_nwords", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            chk("mask_w1", obs_m[0], 4'hF);
            chk("mask_w3", obs_m[2], 4'hC);
            chk("mask_w4", obs_m[3], 4'hC);
            chk("mask_w3_zero", obs_q[2][15:0], 0);
            chk("mask_w4_zero", obs_q[3][15:0], 0);
        end

        for (int i = 0; i < 8; i++) cmem[i] = pk(rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc());
        run_job("bp", 8, 4, 16'($urandom), 5'd12, 1, 0);
        chk("bp_nwords", obs_q.size(), 8);

        run_job("m0", 0, 4, 16'd1, 5'd0, 0, 0);
        chk("m0_done_lat", done_k, 0);
        chk("m0_nwords", obs_q.size(), 0);
        run_job("n0", 3, 0, 16'd1, 5'd0, 0, 0);
        chk("n0_done_lat", done_k, 0);

        for (int i = 0; i < 6; i++) cmem[i] = pk(rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc());
        run_job("inj", 3, 8, 16'd300, 5'd9, 0, 1);
        chk("inj_nwords", obs_q.size(), 6);

        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 32; i++) cmem[i] = pk(rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc());
            run_job("rand", $urandom_range(1, 6), $urandom_range(1, 12),
                    16'($urandom), 5'($urandom_range(0, 20)), 2, 0);
        end

        for (int i = 0; i < 64; i++) cmem[i] = pk(rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc());
        M = 8'd16; N = 8'd16; scale = 16'd1; shift = 5'd0; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_pre_busy", busy, 1);
        chk("midrst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scenario1("s1_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
